// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg -- shared definitions for the write-back stage.
//   * register-address and field widths
//   * src_e : write-data source select (ALU / load / link)
//   * be_e  : load width select (word / half / byte)
// No ports; imported by wb_stage_if, wb_load_ext and wb_stage.
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int RA_W  = 5;  // register address width
  localparam int SRC_W = 2;  // in_src width
  localparam int BE_W  = 2;  // in_be width

  typedef enum logic [SRC_W-1:0] {
    SRC_ALU     = 2'd0,
    SRC_LOAD    = 2'd1,
    SRC_LINK    = 2'd2,
    SRC_ALU_ALT = 2'd3   // unused encoding, behaves as ALU
  } src_e;

  typedef enum logic [BE_W-1:0] {
    BE_WORD = 2'd0,
    BE_HALF = 2'd1,
    BE_BYTE = 2'd2
  } be_e;

endpackage

// File: rtl/wb_stage_if.sv
// -----------------------------------------------------------------------------
// wb_stage_if -- bundle of the write-back stage's bus signals.
//   M->W handshake : in_valid / in_ready, in_flush
//   instruction    : in_we, in_wa, in_src, in_be, in_sext, in_ao, in_dr, in_pc4
//   late channels  : lt_valid / lt_ready, lt_wa (NLT*5), lt_wd (NLT*DW)
//   RF write port  : rf_we, rf_wa, rf_wd
// Modports: slave = the stage itself, master = its environment.
// -----------------------------------------------------------------------------
interface wb_stage_if
  import wb_pkg::*;
#(
  parameter int DW  = 32,
  parameter int NLT = 2
);

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_flush;
  logic                  in_we;
  logic [RA_W-1:0]       in_wa;
  logic [SRC_W-1:0]      in_src;
  logic [BE_W-1:0]       in_be;
  logic                  in_sext;
  logic [DW-1:0]         in_ao;
  logic [DW-1:0]         in_dr;
  logic [DW-1:0]         in_pc4;

  logic [NLT-1:0]        lt_valid;
  logic [NLT-1:0]        lt_ready;
  logic [NLT*RA_W-1:0]   lt_wa;
  logic [NLT*DW-1:0]     lt_wd;

  logic                  rf_we;
  logic [RA_W-1:0]       rf_wa;
  logic [DW-1:0]         rf_wd;

  modport slave (
    input  in_valid, in_flush, in_we, in_wa, in_src, in_be, in_sext,
           in_ao, in_dr, in_pc4, lt_valid, lt_wa, lt_wd,
    output in_ready, lt_ready, rf_we, rf_wa, rf_wd
  );

  modport master (
    output in_valid, in_flush, in_we, in_wa, in_src, in_be, in_sext,
           in_ao, in_dr, in_pc4, lt_valid, lt_wa, lt_wd,
    input  in_ready, lt_ready, rf_we, rf_wa, rf_wd
  );

endinterface

// File: rtl/wb_load_ext.sv
// -----------------------------------------------------------------------------
// wb_load_ext -- combinational load lane select and extension.
//   dr_i   in  DW  raw memory word
//   off_i  in  2   byte offset (ao[1:0]); off_i[0] ignored for half loads
//   be_i   in  2   load width (be_e)
//   sext_i in  1   sign-extend when 1, zero-extend when 0
//   data_o out DW  extended load value
// Lanes are little-endian: byte n = dr[8n+7:8n]. Requires DW >= 32.
// -----------------------------------------------------------------------------
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] dr_i,
  input  logic [1:0]    off_i,
  input  be_e           be_i,
  input  logic          sext_i,
  output logic [DW-1:0] data_o
);

  logic [15:0] half;
  logic [7:0]  byte_v;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    half   = off_i[1] ? dr_i[31:16] : dr_i[15:0];
    byte_v = dr_i[{off_i, 3'b000} +: 8];
    data_o = dr_i;
    case (be_i)
      BE_HALF: data_o = {{(DW-16){sext_i & half[15]}}, half};
      BE_BYTE: data_o = {{(DW-8){sext_i & byte_v[7]}}, byte_v};
      default: data_o = dr_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- pipeline write-back stage with late-result arbitration.
//   clk    in  1  clock, rising edge
//   reset  in  1  synchronous, active-high
//   bus    wb_stage_if.slave  (M->W handshake, late channels, RF write port)
// Parameters: DW datapath width, NLT late channels, STARVE starvation limit.
//
// One stage register holds the accepted instruction; rf_* are driven from it
// combinationally in the following cycle. When the stage is not writing, the
// RF port goes to one late channel chosen round-robin.
//
// Optional feature, macro WB_STARVE_GUARD_EN: a starvation counter forces a
// one-cycle in_ready bubble so a waiting late channel gets the write port.
// -----------------------------------------------------------------------------
module wb_stage
  import wb_pkg::*;
#(
  parameter int DW     = 32,
  parameter int NLT    = 2,
  parameter int STARVE = 4
) (
  input logic       clk,
  input logic       reset,
  wb_stage_if.slave bus
);

  localparam int PTR_W = (NLT > 1) ? $clog2(NLT) : 1;

  // stage register
  logic            valid_q, valid_d;
  logic            we_q;
  logic [RA_W-1:0] wa_q;
  src_e            src_q;
  be_e             be_q;
  logic            sext_q;
  logic [DW-1:0]   ao_q, dr_q, pc4_q;

  logic            accept;
  logic            writing;
  logic            bubble;
  logic [DW-1:0]   load_wd;
  logic [DW-1:0]   stage_wd;

  // late arbitration
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_any;
  logic             grant;
  logic [RA_W-1:0]  lt_wa_sel;
  logic [DW-1:0]    lt_wd_sel;

  // ---------------------------------------------------------------------------
  // Acceptance. A flush still reports in_ready but discards the transfer.
  // ---------------------------------------------------------------------------
  assign accept  = bus.in_valid && bus.in_ready;
  assign valid_d = accept && !bus.in_flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= valid_d;
  end

  // NOTE: payload registers carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q   <= bus.in_we;
      wa_q   <= bus.in_wa;
      src_q  <= src_e'(bus.in_src);
      be_q   <= be_e'(bus.in_be);
      sext_q <= bus.in_sext;
      ao_q   <= bus.in_ao;
      dr_q   <= bus.in_dr;
      pc4_q  <= bus.in_pc4;
    end
  end

  // A write to $0 never occupies the RF port, so late channels may use it.
  assign writing = !reset && valid_q && we_q && (wa_q != '0);

  // ---------------------------------------------------------------------------
  // Write-data formation
  // ---------------------------------------------------------------------------
  wb_load_ext #(.DW(DW)) u_load_ext (
    .dr_i   (dr_q),
    .off_i  (ao_q[1:0]),
    .be_i   (be_q),
    .sext_i (sext_q),
    .data_o (load_wd)
  );

  always_comb begin
    case (src_q)
      SRC_LOAD: stage_wd = load_wd;
      SRC_LINK: stage_wd = pc4_q + DW'(4);
      default:  stage_wd = ao_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Round-robin pick: first requesting channel at or after ptr_q.
  // ---------------------------------------------------------------------------
  always_comb begin
    pick_any = 1'b0;
    pick_idx = ptr_q;
    for (int k = 0; k < NLT; k++) begin
      if (!pick_any && bus.lt_valid[(int'(ptr_q) + k) % NLT]) begin
        pick_any = 1'b1;
        pick_idx = PTR_W'((int'(ptr_q) + k) % NLT);
      end
    end
  end

  assign grant     = !reset && !writing && pick_any;
  assign lt_wa_sel = bus.lt_wa[int'(pick_idx)*RA_W +: RA_W];
  assign lt_wd_sel = bus.lt_wd[int'(pick_idx)*DW +: DW];

  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = (pick_idx == PTR_W'(NLT-1)) ? '0 : pick_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  always_comb begin
    bus.lt_ready = '0;
    if (grant) bus.lt_ready[pick_idx] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // RF write port: stage has priority; a granted late write to $0 completes
  // its handshake without asserting rf_we.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.rf_we = 1'b0;
    bus.rf_wa = wa_q;
    bus.rf_wd = stage_wd;
    if (writing) begin
      bus.rf_we = 1'b1;
    end else if (grant) begin
      bus.rf_we = (lt_wa_sel != '0);
      bus.rf_wa = lt_wa_sel;
      bus.rf_wd = lt_wd_sel;
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation guard
  // ---------------------------------------------------------------------------
`ifdef WB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE + 1);

  logic [CNT_W-1:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (grant || !(|bus.lt_valid))           starve_d = '0;
    else if (starve_q != CNT_W'(STARVE))     starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

  // The bubble is needed only while the stage still holds the port; refusing
  // the next instruction guarantees the following cycle is free. Once the
  // stage empties, the grant itself clears the counter.
  assign bubble = (starve_q == CNT_W'(STARVE)) && writing;
`else
  assign bubble = 1'b0;
`endif

  assign bus.in_ready = !reset && !bubble;

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage -- directed bench for wb_stage (DW=32, NLT=2, STARVE=4).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// Table of single-instruction vectors plus hand sequences for reset,
// round-robin, flush, reset mid-operation and starvation.
// -----------------------------------------------------------------------------
module tb_wb_stage;
  import wb_pkg::*;

  localparam int DW  = 32;
  localparam int NLT = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  wb_stage_if #(.DW(DW), .NLT(NLT)) bus ();

  wb_stage #(.DW(DW), .NLT(NLT), .STARVE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_flush = 1'b0;
    bus.in_we    = 1'b0;
    bus.in_wa    = '0;
    bus.in_src   = '0;
    bus.in_be    = '0;
    bus.in_sext  = 1'b0;
    bus.in_ao    = '0;
    bus.in_dr    = '0;
    bus.in_pc4   = '0;
    bus.lt_valid = '0;
    bus.lt_wa    = '0;
    bus.lt_wd    = '0;
  endtask

  task automatic drive_instr(input logic we, input logic [4:0] wa, input logic [1:0] src,
                             input logic [1:0] be, input logic sext, input logic [31:0] ao,
                             input logic [31:0] dr, input logic [31:0] pc4);
    bus.in_valid = 1'b1;
    bus.in_we    = we;
    bus.in_wa    = wa;
    bus.in_src   = src;
    bus.in_be    = be;
    bus.in_sext  = sext;
    bus.in_ao    = ao;
    bus.in_dr    = dr;
    bus.in_pc4   = pc4;
  endtask

  task automatic set_late(input int ch, input logic [4:0] wa, input logic [31:0] wd);
    bus.lt_wa[ch*5 +: 5]   = wa;
    bus.lt_wd[ch*32 +: 32] = wd;
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  wa;
    logic [1:0]  src;
    logic [1:0]  be;
    logic        sext;
    logic [31:0] ao;
    logic [31:0] dr;
    logic [31:0] pc4;
    logic [1:0]  lt_valid;
    logic [4:0]  lt_wa0;
    logic [31:0] lt_wd0;
    logic        exp_we;
    logic [4:0]  exp_wa;
    logic [31:0] exp_wd;
    logic [1:0]  exp_lt_ready;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //             name            we wa  src be sx ao            dr            pc4           ltv    lwa lwd0          ewe ewa ewd           elr
    vecs[0]  = '{"ld_b_sext",     1, 5,  1,  2, 1, 32'h0000_1001, 32'h8070_F0A5, 32'h0,        2'b00, 0,  32'h0,        1,  5,  32'hFFFF_FFF0, 2'b00};
    vecs[1]  = '{"ld_b_zext",     1, 5,  1,  2, 0, 32'h0000_1001, 32'h8070_F0A5, 32'h0,        2'b00, 0,  32'h0,        1,  5,  32'h0000_00F0, 2'b00};
    vecs[2]  = '{"link",          1, 31, 2,  0, 0, 32'h0,         32'h0,         32'h0000_3004, 2'b00, 0,  32'h0,        1,  31, 32'h0000_3008, 2'b00};
    vecs[3]  = '{"alu",           1, 3,  0,  0, 0, 32'hDEAD_BEEF, 32'h0,         32'h0,        2'b00, 0,  32'h0,        1,  3,  32'hDEAD_BEEF, 2'b00};
    vecs[4]  = '{"src3_alu",      1, 7,  3,  0, 0, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0100, 2'b00, 0,  32'h0,        1,  7,  32'h1234_5678, 2'b00};
    vecs[5]  = '{"ld_h_hi_sext",  1, 9,  1,  1, 1, 32'h0000_0003, 32'h8070_F0A5, 32'h0,        2'b00, 0,  32'h0,        1,  9,  32'hFFFF_8070, 2'b00};
    vecs[6]  = '{"ld_h_lo_zext",  1, 9,  1,  1, 0, 32'h0000_0001, 32'h8070_F0A5, 32'h0,        2'b00, 0,  32'h0,        1,  9,  32'h0000_F0A5, 2'b00};
    vecs[7]  = '{"ld_b3_sext",    1, 10, 1,  2, 1, 32'h0000_0003, 32'h8070_F0A5, 32'h0,        2'b00, 0,  32'h0,        1,  10, 32'hFFFF_FF80, 2'b00};
    vecs[8]  = '{"ld_b2_sext",    1, 10, 1,  2, 1, 32'h0000_0002, 32'h8070_F0A5, 32'h0,        2'b00, 0,  32'h0,        1,  10, 32'h0000_0070, 2'b00};
    vecs[9]  = '{"ld_word",       1, 11, 1,  0, 1, 32'h0000_0000, 32'h8070_F0A5, 32'h0,        2'b00, 0,  32'h0,        1,  11, 32'h8070_F0A5, 2'b00};
    vecs[10] = '{"we_off",        0, 9,  0,  0, 0, 32'h0000_1111, 32'h0,         32'h0,        2'b00, 0,  32'h0,        0,  0,  32'h0,         2'b00};
    vecs[11] = '{"r0_late_grant", 1, 0,  0,  0, 0, 32'h0000_2222, 32'h0,         32'h0,        2'b01, 4,  32'hAAAA_0000, 1,  4,  32'hAAAA_0000, 2'b01};
    vecs[12] = '{"stage_wins",    1, 2,  0,  0, 0, 32'h0000_5555, 32'h0,         32'h0,        2'b10, 6,  32'h0,        1,  2,  32'h0000_5555, 2'b00};
    vecs[13] = '{"late_to_r0",    0, 0,  0,  0, 0, 32'h0,         32'h0,         32'h0,        2'b01, 0,  32'h0000_CCCC, 0,  0,  32'h0,         2'b01};

    // ---------------- reset state ----------------
    idle_inputs();
    reset = 1'b1;
    drive_instr(1, 5'd20, 2'd0, 2'd0, 1'b0, 32'h0000_0BAD, 32'h0, 32'h0);
    bus.lt_valid = 2'b11;
    set_late(0, 5'd10, 32'h0000_00C0);
    set_late(1, 5'd11, 32'h0000_00C1);
    repeat (2) @(negedge clk);
    #1;
    check("reset_rf_we",    bus.rf_we,    0);
    check("reset_lt_ready", bus.lt_ready, 2'b00);
    check("reset_in_ready", bus.in_ready, 0);

    // ---------------- round-robin, empty stage ----------------
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    bus.lt_valid = 2'b11;
    set_late(0, 5'd10, 32'h0000_00C0);
    set_late(1, 5'd11, 32'h0000_00C1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check($sformatf("rr%0d_lt_ready", k), bus.lt_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("rr%0d_rf_we", k),    bus.rf_we, 1);
      check($sformatf("rr%0d_rf_wd", k),    bus.rf_wd, (k % 2 == 0) ? 32'h0000_00C0 : 32'h0000_00C1);
    end
    @(negedge clk);
    bus.lt_valid = 2'b00;

    // ---------------- table vectors ----------------
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      idle_inputs();
      drive_instr(vecs[i].we, vecs[i].wa, vecs[i].src, vecs[i].be, vecs[i].sext,
                  vecs[i].ao, vecs[i].dr, vecs[i].pc4);
      @(negedge clk);
      idle_inputs();
      bus.lt_valid = vecs[i].lt_valid;
      set_late(0, vecs[i].lt_wa0, vecs[i].lt_wd0);
      set_late(1, 5'd8, 32'hBBBB_0001);
      #1;
      check({vecs[i].name, "_rf_we"}, bus.rf_we, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        check({vecs[i].name, "_rf_wa"}, bus.rf_wa, vecs[i].exp_wa);
        check({vecs[i].name, "_rf_wd"}, bus.rf_wd, vecs[i].exp_wd);
      end
      check({vecs[i].name, "_lt_ready"}, bus.lt_ready, vecs[i].exp_lt_ready);
      check({vecs[i].name, "_in_ready"}, bus.in_ready, 1);
      @(negedge clk);
      idle_inputs();
      #1;
      check({vecs[i].name, "_idle_rf_we"}, bus.rf_we, 0);
    end

    // ---------------- flush coincident with acceptance ----------------
    @(negedge clk);
    idle_inputs();
    drive_instr(1, 5'd6, 2'd0, 2'd0, 1'b0, 32'h0000_0077, 32'h0, 32'h0);
    bus.in_flush = 1'b1;
    bus.lt_valid = 2'b01;
    set_late(0, 5'd12, 32'h0000_F1F1);
    #1;
    check("flush_in_ready", bus.in_ready, 1);
    check("flush_lt_ready", bus.lt_ready, 2'b01);
    check("flush_lt_rf_wa", bus.rf_wa, 5'd12);
    @(negedge clk);
    idle_inputs();
    #1;
    check("flush_no_write", bus.rf_we, 0);

    // ---------------- reset with stage valid (pointer is 1 here) ----------------
    @(negedge clk);
    drive_instr(1, 5'd13, 2'd0, 2'd0, 1'b0, 32'h0000_0099, 32'h0, 32'h0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    check("rst_mid_rf_we",    bus.rf_we, 0);
    check("rst_mid_in_ready", bus.in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.lt_valid = 2'b11;
    set_late(0, 5'd10, 32'h0000_00C0);
    set_late(1, 5'd11, 32'h0000_00C1);
    #1;
    check("rst_ptr_zero_lt_ready", bus.lt_ready, 2'b01);
    check("rst_ptr_zero_rf_wa",    bus.rf_wa, 5'd10);
    @(negedge clk);
    idle_inputs();

    // ---------------- starvation: back-to-back writes, channel 1 waiting ----------------
    @(negedge clk);
    drive_instr(1, 5'd14, 2'd0, 2'd0, 1'b0, 32'h0000_1400, 32'h0, 32'h0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      bus.in_ao    = 32'h0000_1400 + 32'(c);
      bus.lt_valid = 2'b10;
      set_late(1, 5'd15, 32'hBEEF_0015);
      #1;
`ifdef WB_STARVE_GUARD_EN
      check($sformatf("starve_c%0d_in_ready", c), bus.in_ready, (c == 5) ? 1'b0 : 1'b1);
      check($sformatf("starve_c%0d_lt_ready", c), bus.lt_ready, (c == 6) ? 2'b10 : 2'b00);
      if (c == 6) begin
        check("starve_c6_rf_wa", bus.rf_wa, 5'd15);
        check("starve_c6_rf_wd", bus.rf_wd, 32'hBEEF_0015);
      end
`else
      check($sformatf("nostarve_c%0d_in_ready", c), bus.in_ready, 1);
      check($sformatf("nostarve_c%0d_lt_ready", c), bus.lt_ready, 2'b00);
      check($sformatf("nostarve_c%0d_rf_wa", c),    bus.rf_wa, 5'd14);
`endif
    end
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
